// File: rtl/gpio_input_conditioner.sv
// GPIO input front-end: per-bit synchroniser, debounce counter, registered
// edge pulses and sticky change flags for software polling.
module gpio_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Raw_In,
  input  logic [WIDTH-1:0] Flag_Clr,
  output logic [WIDTH-1:0] Stable_Out,
  output logic [WIDTH-1:0] Rise_Pulse,
  output logic [WIDTH-1:0] Fall_Pulse,
  output logic [WIDTH-1:0] Change_Flag
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift the raw pins through the synchroniser chain.
  always_comb begin
    sync_d[0] = Raw_In;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-bit debounce: count disagreeing cycles, accept on terminal count.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    accept   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]    = '0;
        stable_d[i] = sync_s[i];
        rise_d[i]   = sync_s[i];
        fall_d[i]   = ~sync_s[i];
        accept[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // A new acceptance beats a simultaneous software clear.
    flag_d = accept | (flag_q & ~Flag_Clr);
  end

  // State registers; async reset drops any pending debounce counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      flag_q   <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      flag_q   <= flag_d;
    end
  end

  assign Stable_Out  = stable_q;
  assign Rise_Pulse  = rise_q;
  assign Fall_Pulse  = fall_q;
  assign Change_Flag = flag_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Table rows and hand sequences push expected outputs into a queue; they are
// popped and compared just after the posedge that should produce them.
module tb_gpio_input_conditioner;

  logic       clk;
  logic       rst;
  logic [7:0] Raw_In;
  logic [7:0] Flag_Clr;
  logic [7:0] Stable_Out;
  logic [7:0] Rise_Pulse;
  logic [7:0] Fall_Pulse;
  logic [7:0] Change_Flag;

  gpio_input_conditioner #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Raw_In(Raw_In),
    .Flag_Clr(Flag_Clr),
    .Stable_Out(Stable_Out),
    .Rise_Pulse(Rise_Pulse),
    .Fall_Pulse(Fall_Pulse),
    .Change_Flag(Change_Flag)
  );

  typedef struct {
    bit         r;
    logic [7:0] raw;
    logic [7:0] clr;
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] flag;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] flag;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  function automatic void add(input bit r, input logic [7:0] raw, input logic [7:0] clr,
                              input logic [7:0] st, input logic [7:0] ri,
                              input logic [7:0] fa, input logic [7:0] fl, input string nm);
    vec_t v;
    v.r = r; v.raw = raw; v.clr = clr;
    v.stable = st; v.rise = ri; v.fall = fa; v.flag = fl; v.name = nm;
    tbl.push_back(v);
  endfunction

  // One clock: drive at negedge, queue expectation, compare after posedge.
  task automatic step(input bit r, input logic [7:0] raw, input logic [7:0] clr,
                      input logic [7:0] st, input logic [7:0] ri,
                      input logic [7:0] fa, input logic [7:0] fl, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; Raw_In = raw; Flag_Clr = clr;
    e.stable = st; e.rise = ri; e.fall = fa; e.flag = fl; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", nm);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".stable"}, Stable_Out,  e.stable);
      chk({e.name, ".rise"},   Rise_Pulse,  e.rise);
      chk({e.name, ".fall"},   Fall_Pulse,  e.fall);
      chk({e.name, ".flag"},   Change_Flag, e.flag);
    end
  endtask

  initial begin
    logic [7:0] raw6;
    rst = 1'b1; Raw_In = 8'hFF; Flag_Clr = 8'h00;
    #2;
    chk("rst_async.stable", Stable_Out, 8'h00);
    chk("rst_async.rise",   Rise_Pulse, 8'h00);
    chk("rst_async.flag",   Change_Flag, 8'h00);

    // Reset release with all pins high: accept after posedge 6.
    add(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "t1_rst");
    for (int c = 1; c <= 5; c++) add(0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "t1_wait");
    add(0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, "t1_accept");
    add(0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, "t1_pulse_end");
    add(0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, "t1_clr");
    add(0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, "t1_idle");
    // Upper nibble falls together.
    for (int c = 1; c <= 5; c++) add(0, 8'h0F, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, "tf_wait");
    add(0, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'hF0, "tf_accept");
    add(0, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00, 8'hF0, "tf_pulse_end");
    add(0, 8'h0F, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, "tf_clr");
    // Bit 0 falls; clear on the accepting edge loses to the set.
    for (int c = 1; c <= 5; c++) add(0, 8'h0E, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, "t3_wait");
    add(0, 8'h0E, 8'h01, 8'h0E, 8'h00, 8'h01, 8'h01, "t4_clr_race");
    add(0, 8'h0E, 8'h01, 8'h0E, 8'h00, 8'h00, 8'h00, "t4_clr");
    add(0, 8'h0E, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, "t4_idle");
    // 3-cycle glitch on bit 0 is rejected.
    for (int c = 1; c <= 3; c++) add(0, 8'h0F, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, "t2_glitch");
    for (int c = 4; c <= 10; c++) add(0, 8'h0E, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, "t2_after");
    // 4-cycle pulse on bit 0 is exactly long enough, then returns.
    for (int c = 1; c <= 4; c++) add(0, 8'h0F, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, "tb4_high");
    add(0, 8'h0E, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, "tb4_wait");
    add(0, 8'h0E, 8'h00, 8'h0F, 8'h01, 8'h00, 8'h01, "tb4_rise");
    for (int c = 7; c <= 9; c++) add(0, 8'h0E, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h01, "tb4_hold");
    add(0, 8'h0E, 8'h00, 8'h0E, 8'h00, 8'h01, 8'h01, "tb4_fall");
    add(0, 8'h0E, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h01, "tb4_idle");
    add(0, 8'h0E, 8'hFF, 8'h0E, 8'h00, 8'h00, 8'h00, "tb4_clr");

    foreach (tbl[n]) begin
      step(tbl[n].r, tbl[n].raw, tbl[n].clr, tbl[n].stable,
           tbl[n].rise, tbl[n].fall, tbl[n].flag, tbl[n].name);
    end

    // Mid-debounce async reset: pending counts lost, restart from scratch.
    for (int c = 1; c <= 4; c++) step(0, 8'h55, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, "t5_pre");
    #1 rst = 1'b1;
    #1;
    chk("t5_rst.stable", Stable_Out,  8'h00);
    chk("t5_rst.rise",   Rise_Pulse,  8'h00);
    chk("t5_rst.fall",   Fall_Pulse,  8'h00);
    chk("t5_rst.flag",   Change_Flag, 8'h00);
    #1 rst = 1'b0;
    for (int c = 1; c <= 5; c++) step(0, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "t5_wait");
    step(0, 8'h55, 8'h00, 8'h55, 8'h55, 8'h00, 8'h55, "t5_accept");
    step(0, 8'h55, 8'h00, 8'h55, 8'h00, 8'h00, 8'h55, "t5_pulse_end");
    step(0, 8'h55, 8'hFF, 8'h55, 8'h00, 8'h00, 8'h00, "t5_clr");

    // Bit 3 bounces for 10 cycles then holds high: one rise, 6 cycles later.
    for (int k = 1; k <= 19; k++) begin
      raw6 = 8'h55;
      raw6[3] = (k <= 10) ? k[0] : 1'b1;
      step(0, raw6, 8'h00,
           (k >= 16) ? 8'h5D : 8'h55,
           (k == 16) ? 8'h08 : 8'h00,
           8'h00,
           (k >= 16) ? 8'h08 : 8'h00,
           "t6_bounce");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
